uart_sample_responder: RTL and testbench
========================================

# uart_sample_responder

Parametrised UART command responder that sits between the `async_receiver`/`async_transmitter` pair and the sensor readout in the DE0-Nano top level. A received command byte selects one of `NUM_CH` sample channels. The block drives the channel select to the sensor front end and waits for a fresh sample. It then returns a framed reply: an echo byte followed by the sample, LSB byte first. Malformed commands, sample timeouts and overrun are handled explicitly. Everything runs in the single `CLK_50` domain.

## Interface
- `NUM_CH`, 3: number of selectable channels, 1..16
- `SAMPLE_W`, 16: sample width in bits, 1..32; `NBYTES = ceil(SAMPLE_W/8)`
- `CMD_BASE`, 8'h78 ('x'): command byte for channel 0; channel k = `CMD_BASE+k`
- `NAK_BYTE`, 8'h3F ('?'): reply to an unknown command
- `TMO_BYTE`, 8'h21 ('!'): reply when no sample arrives in time
- `TIMEOUT_CYC`, 50000: sample-wait limit in clock cycles, ≥2

Ports:
- `CLK_50` in 1: clock
- `iRSTN` in 1: reset, asynchronous, active-low
- `rx_valid` in 1: one-cycle strobe, received byte present
- `rx_data` in 8: received byte, valid with `rx_valid`
- `tx_start` out 1: one-cycle start strobe to the transmitter
- `tx_data` out 8: byte to send, held stable from `tx_start` until the byte completes
- `tx_busy` in 1: transmitter busy
- `ch_sel` out `max(1,clog2(NUM_CH))`: channel select to the sensor front end
- `sample_in` in `SAMPLE_W`: sample from the selected channel
- `sample_valid` in 1: one-cycle strobe, `sample_in` valid
- `busy` out 1: high whenever the state is not IDLE
- `overrun_cnt` out 8: saturating count of bytes dropped while busy

## Operation
- Reset values: `tx_start` 0, `tx_data` 0, `ch_sel` 0, `busy` 0, `overrun_cnt` 0, state IDLE, latched sample 0.
- States:
  - IDLE, WAIT_SAMPLE, TX_LOAD, TX_WAIT.
  - Byte index counter: 0..NBYTES.
  - Timeout counter: width `clog2(TIMEOUT_CYC+1)`.
- IDLE, on `rx_valid`:
  - If `CMD_BASE <= rx_data < CMD_BASE+NUM_CH`: latch the command byte, set `ch_sel = rx_data-CMD_BASE`, clear the timeout counter, go to WAIT_SAMPLE.
  - Otherwise: reply byte = `NAK_BYTE`, frame length 1, go to TX_LOAD.
  - Range compare uses 9-bit arithmetic so `CMD_BASE+NUM_CH > 255` does not wrap.
- WAIT_SAMPLE:
  - A `sample_valid` in the same cycle `ch_sel` was written is ignored (stale channel).
  - The first `sample_valid` after that is latched. Zero-extend the sample to `8*NBYTES` bits. Frame = {echo command byte, NBYTES sample bytes LSB first}. Go to TX_LOAD.
  - Timeout counter increments every cycle. At `TIMEOUT_CYC` with no sample: frame = {`TMO_BYTE`}, length 1, go to TX_LOAD.
  - If `sample_valid` and timeout occur in the same cycle, the sample wins.
- TX_LOAD:
  - While `tx_busy`=1: wait.
  - When `tx_busy`=0: drive `tx_data` = current frame byte, pulse `tx_start` for exactly 1 cycle, go to TX_WAIT.
- TX_WAIT:
  - Ignore `tx_busy` in the first cycle; the transmitter raises busy one cycle after start.
  - Then wait for `tx_busy`=0.
  - If more bytes remain: increment the index, go to TX_LOAD. Otherwise go to IDLE.
- `rx_valid` in any non-IDLE state: byte dropped, `overrun_cnt` += 1, saturating at 255. The frame is never corrupted.
- `rx_valid` in the cycle the block returns to IDLE: counted as an overrun. A byte is accepted only while the registered state is IDLE.
- `iRSTN` low mid-frame: immediate return to reset values. No partial byte is re-sent after release.

## Timing
- Command `rx_valid` at cycle n → `ch_sel` valid at n+1. The earliest sample accepted is at n+2.
- Sample accepted at m → first `tx_start` at m+1 if `tx_busy`=0. Each `tx_start` is separated by one full transmitter byte time plus 2 cycles.
- NAK: `rx_valid` at n → `tx_start` with `NAK_BYTE` at n+1 if idle.
- Timeout: `TMO_BYTE` `tx_start` at n+1+`TIMEOUT_CYC`+1.
- `busy` deasserts in the cycle after the last byte's `tx_busy` falls.

## Structure
- Shared package `uart_resp_pkg`:
  - state enum
  - default `CMD_BASE`/`NAK_BYTE`/`TMO_BYTE` constants
  - `nbytes(w)` function
- Natural sub-module: `uart_frame_tx`. It holds the frame shift buffer, byte index and TX_LOAD/TX_WAIT handshake. Inputs: load strobe, frame vector and length. Output: done strobe.
- The parent keeps command decode, channel select, timeout and the overrun counter.

## Test plan
- Channel command: defaults, send 8'h79, then `sample_valid` with `sample_in`=16'hA5C3 → `ch_sel`=1; bytes out 8'h79, 8'hC3, 8'hA5; `busy` falls after the third byte.
- Stale sample: `sample_valid` in the same cycle as `ch_sel` update (value 16'h1111), next strobe 16'h2222 → payload 8'h22, 8'h22.
- Bad command: send 8'h41 → single 8'h3F, `ch_sel` unchanged, no sample wait.
- Timeout: `TIMEOUT_CYC`=100, send 8'h7A, no `sample_valid` → single 8'h21 at cycle n+102; then `sample_valid` at n+102 while in TX_LOAD is ignored.
- Overrun and odd width: `SAMPLE_W`=12, sample 12'hFAB → bytes cmd, 8'hAB, 8'h0F. 300 `rx_valid` strobes during the reply → `overrun_cnt`=255.
- Reset mid-frame: `iRSTN` low after the 2nd `tx_start` → all outputs at reset values. After release no further `tx_start`, and a new command is served normally.

Source files
------------

// File: rtl/uart_resp_pkg.sv
// Shared state encoding, default reply bytes and byte-count helper for the
// UART sample responder and its frame transmitter.
package uart_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_SAMPLE = 2'd1,
    ST_TX_LOAD     = 2'd2,
    ST_TX_WAIT     = 2'd3
  } resp_state_e;

  localparam logic [7:0] DEF_CMD_BASE = 8'h78;
  localparam logic [7:0] DEF_NAK_BYTE = 8'h3F;
  localparam logic [7:0] DEF_TMO_BYTE = 8'h21;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Sends a loaded frame byte by byte, LSB byte first, through a start/busy
// transmitter handshake and strobes done_o once the last byte has gone out.
module uart_frame_tx
  import uart_resp_pkg::*;
#(
  parameter int FRAME_W = 24,
  parameter int CNT_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [CNT_W-1:0]   len_i,
  input  logic               tx_busy_i,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o,
  output logic               done_o
);

  resp_state_e        state_q, state_d;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               first_q, first_d;
  logic [CNT_W-1:0]   idx_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      first_q <= first_d;
    end
  end

  // The buffer only shifts once a byte has completed, so tx_data_o stays
  // stable for the whole time the transmitter is working on it.
  assign tx_data_o = buf_q[7:0];

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    len_d      = len_q;
    first_d    = 1'b0;
    tx_start_o = 1'b0;
    done_o     = 1'b0;
    idx_nxt    = idx_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          buf_d   = frame_i;
          len_d   = len_i;
          idx_d   = '0;
          state_d = ST_TX_LOAD;
        end
      end
      ST_TX_LOAD: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          first_d    = 1'b1;
          state_d    = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        // The transmitter raises busy one cycle after start; skip that cycle.
        if (!first_q && !tx_busy_i) begin
          if (idx_nxt < len_q) begin
            idx_d   = idx_nxt;
            buf_d   = buf_q >> 8;
            state_d = ST_TX_LOAD;
          end else begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_sample_responder.sv
// UART command responder: decodes a channel command, waits for a fresh
// sample and replies with an echo byte plus the sample, LSB byte first.
module uart_sample_responder
  import uart_resp_pkg::*;
#(
  parameter int         NUM_CH      = 3,
  parameter int         SAMPLE_W    = 16,
  parameter logic [7:0] CMD_BASE    = DEF_CMD_BASE,
  parameter logic [7:0] NAK_BYTE    = DEF_NAK_BYTE,
  parameter logic [7:0] TMO_BYTE    = DEF_TMO_BYTE,
  parameter int         TIMEOUT_CYC = 50000,
  localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                CLK_50,
  input  logic                iRSTN,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  output logic [CH_W-1:0]     ch_sel,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  localparam int NBYTES  = nbytes(SAMPLE_W);
  localparam int FRAME_W = 8 * (NBYTES + 1);
  localparam int CNT_W   = $clog2(NBYTES + 2);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  // ST_TX_LOAD here covers the whole frame transmission; the byte-level
  // load/wait handshake lives in uart_frame_tx.
  resp_state_e        state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [CH_W-1:0]    ch_sel_q, ch_sel_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         ovr_q, ovr_d;

  logic               frame_load;
  logic [FRAME_W-1:0] frame_vec;
  logic [CNT_W-1:0]   frame_len;
  logic               frame_done;
  logic [8:0]         rx9, base9, lim9;
  logic               cmd_hit;
  logic [8*NBYTES-1:0] sample_ext;

  // 9-bit compare so a channel range running past 8'hFF does not wrap.
  assign rx9        = {1'b0, rx_data};
  assign base9      = {1'b0, CMD_BASE};
  assign lim9       = base9 + 9'(NUM_CH);
  assign cmd_hit    = (rx9 >= base9) && (rx9 < lim9);
  assign sample_ext = (8*NBYTES)'(sample_in);

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      ch_sel_q <= '0;
      tmo_q    <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      ch_sel_q <= ch_sel_d;
      tmo_q    <= tmo_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ch_sel_d   = ch_sel_q;
    tmo_d      = tmo_q;
    ovr_d      = ovr_q;
    frame_load = 1'b0;
    frame_vec  = '0;
    frame_len  = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (cmd_hit) begin
            cmd_d    = rx_data;
            ch_sel_d = CH_W'(rx_data - CMD_BASE);
            tmo_d    = '0;
            state_d  = ST_WAIT_SAMPLE;
          end else begin
            frame_load = 1'b1;
            frame_vec  = FRAME_W'(NAK_BYTE);
            frame_len  = CNT_W'(1);
            state_d    = ST_TX_LOAD;
          end
        end
      end
      ST_WAIT_SAMPLE: begin
        // A zero count marks the cycle ch_sel changed: that strobe belongs
        // to the previous channel and is skipped.
        if (sample_valid && (tmo_q != '0)) begin
          frame_load = 1'b1;
          frame_vec  = {sample_ext, cmd_q};
          frame_len  = CNT_W'(NBYTES + 1);
          state_d    = ST_TX_LOAD;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
          frame_load = 1'b1;
          frame_vec  = FRAME_W'(TMO_BYTE);
          frame_len  = CNT_W'(1);
          state_d    = ST_TX_LOAD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_TX_LOAD: begin
        if (frame_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rx_valid && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  uart_frame_tx #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_frame_tx (
    .clk_i      (CLK_50),
    .rst_ni     (iRSTN),
    .load_i     (frame_load),
    .frame_i    (frame_vec),
    .len_i      (frame_len),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .done_o     (frame_done)
  );

  assign ch_sel      = ch_sel_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_uart_sample_responder.sv
// Bench for uart_sample_responder: a 16-bit and a 12-bit instance share a
// clock, each served by a simple busy-for-N-cycles transmitter model.
module tb_uart_sample_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       rx_valid, tx_start, tx_busy, sample_valid, busy;
  logic [1:0][7:0]  rx_data, tx_data, ovr;
  logic [1:0][1:0]  ch_sel;
  logic [1:0][15:0] sample_in;

  uart_sample_responder #(.NUM_CH(3), .SAMPLE_W(16), .TIMEOUT_CYC(100)) dut0 (
    .CLK_50(clk), .iRSTN(rst_n), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_busy(tx_busy[0]),
    .ch_sel(ch_sel[0]), .sample_in(sample_in[0]), .sample_valid(sample_valid[0]),
    .busy(busy[0]), .overrun_cnt(ovr[0])
  );

  uart_sample_responder #(.NUM_CH(3), .SAMPLE_W(12), .TIMEOUT_CYC(100)) dut1 (
    .CLK_50(clk), .iRSTN(rst_n), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_busy(tx_busy[1]),
    .ch_sel(ch_sel[1]), .sample_in(sample_in[1][11:0]), .sample_valid(sample_valid[1]),
    .busy(busy[1]), .overrun_cnt(ovr[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bt [2];
  int bcnt0 = 0;
  int bcnt1 = 0;
  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  int         capc0 [$];
  int         capc1 [$];
  logic [7:0] exp_q [$];

  // Transmitter model: records each started byte and its cycle, then stays
  // busy for bt[i] cycles starting the cycle after the start strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start[0]) begin
      cap0.push_back(tx_data[0]);
      capc0.push_back(cyc);
      bcnt0 <= bt[0];
    end else if (bcnt0 > 0) begin
      bcnt0 <= bcnt0 - 1;
    end
    if (tx_start[1]) begin
      cap1.push_back(tx_data[1]);
      capc1.push_back(cyc);
      bcnt1 <= bt[1];
    end else if (bcnt1 > 0) begin
      bcnt1 <= bcnt1 - 1;
    end
  end
  assign tx_busy[0] = (bcnt0 > 0);
  assign tx_busy[1] = (bcnt1 > 0);

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input int i, input logic [7:0] b, output int n);
    n = cyc;
    rx_valid[i] = 1'b1;
    rx_data[i]  = b;
    tick();
    rx_valid[i] = 1'b0;
  endtask

  task automatic pulse_sample(input int i, input logic [15:0] v, output int m);
    m = cyc;
    sample_valid[i] = 1'b1;
    sample_in[i]    = v;
    tick();
    sample_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, output int c);
    int k;
    k = 0;
    while (busy[i] !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    c = cyc;
    chk("idle_within_budget", 32'(k < budget), 32'd1);
  endtask

  function automatic int start_cyc(input int i, input int k);
    if (i == 0) return (k < capc0.size()) ? capc0[k] : -1;
    return (k < capc1.size()) ? capc1[k] : -1;
  endfunction

  task automatic check_frame(input int i, input int base, input string tag);
    int got;
    logic [7:0] g;
    got = (i == 0) ? cap0.size() - base : cap1.size() - base;
    chk({tag, "_len"}, got, exp_q.size());
    foreach (exp_q[k]) begin
      if (k < got) g = (i == 0) ? cap0[base+k] : cap1[base+k];
      else g = 8'hxx;
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, g}, {24'd0, exp_q[k]});
    end
  endtask

  task automatic set_exp(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2);
    exp_q.delete();
    exp_q.push_back(b0);
    if (nb > 1) exp_q.push_back(b1);
    if (nb > 2) exp_q.push_back(b2);
  endtask

  int n, m, c, base, cnt, dly;
  logic [7:0]  b;
  logic [15:0] s;
  bit          hit;

  initial begin
    rst_n = 1'b0;
    rx_valid = '0; rx_data = '0; sample_valid = '0; sample_in = '0;
    bt[0] = 5;
    bt[1] = 120;
    repeat (3) tick();
    chk("rst_tx_start", tx_start, 2'b00);
    chk("rst_tx_data", tx_data, 16'h0000);
    chk("rst_ch_sel", ch_sel, 4'h0);
    chk("rst_busy", busy, 2'b00);
    chk("rst_overrun", ovr, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Channel command with a valid sample.
    base = cap0.size();
    send_rx(0, 8'h79, n);
    chk("ch1_ch_sel", ch_sel[0], 2'd1);
    chk("ch1_busy", busy[0], 1'b1);
    tick();
    pulse_sample(0, 16'hA5C3, m);
    wait_idle(0, 200, c);
    set_exp(3, 8'h79, 8'hC3, 8'hA5);
    check_frame(0, base, "ch1");
    chk("ch1_first_start", start_cyc(0, base), m + 1);
    chk("ch1_spacing", start_cyc(0, base + 1) - start_cyc(0, base), bt[0] + 2);
    chk("ch1_busy_fall", c, start_cyc(0, base + 2) + bt[0] + 2);

    // Unknown command: immediate NAK, channel select untouched.
    base = cap0.size();
    send_rx(0, 8'h41, n);
    chk("nak_ch_sel", ch_sel[0], 2'd1);
    wait_idle(0, 50, c);
    set_exp(1, 8'h3F, 8'h00, 8'h00);
    check_frame(0, base, "nak");
    chk("nak_start", start_cyc(0, base), n + 1);

    // Stale sample in the channel-switch cycle is skipped.
    base = cap0.size();
    send_rx(0, 8'h78, n);
    sample_valid[0] = 1'b1;
    sample_in[0]    = 16'h1111;
    tick();
    sample_in[0]    = 16'h2222;
    tick();
    sample_valid[0] = 1'b0;
    wait_idle(0, 200, c);
    set_exp(3, 8'h78, 8'h22, 8'h22);
    check_frame(0, base, "stale");
    chk("stale_start", start_cyc(0, base), n + 3);

    // Sample timeout, then a late sample while the reply is pending.
    base = cap0.size();
    send_rx(0, 8'h7A, n);
    chk("tmo_ch_sel", ch_sel[0], 2'd2);
    for (int k = 0; k < 101; k++) tick();
    chk("tmo_start_now", tx_start[0], 1'b1);
    pulse_sample(0, 16'hBEEF, m);
    wait_idle(0, 200, c);
    set_exp(1, 8'h21, 8'h00, 8'h00);
    check_frame(0, base, "tmo");
    chk("tmo_start", start_cyc(0, base), n + 102);

    // Randomized commands against the frame model.
    for (int it = 0; it < 20; it++) begin
      b   = ($urandom_range(0, 1) == 1) ? 8'(8'h78 + $urandom_range(0, 2)) : 8'($urandom);
      s   = 16'($urandom);
      hit = (b >= 8'h78) && (b < 8'h7B);
      base = cap0.size();
      send_rx(0, b, n);
      if (hit) begin
        chk($sformatf("rnd%0d_ch_sel", it), ch_sel[0], 32'(b - 8'h78));
        dly = $urandom_range(1, 3);
        repeat (dly) tick();
        pulse_sample(0, s, m);
        set_exp(3, b, s[7:0], s[15:8]);
      end else begin
        m = n;
        set_exp(1, 8'h3F, 8'h00, 8'h00);
      end
      wait_idle(0, 200, c);
      check_frame(0, base, $sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_start", it), start_cyc(0, base), m + 1);
    end

    // 12-bit sample and overrun saturation on the second instance.
    base = cap1.size();
    send_rx(1, 8'h79, n);
    tick();
    pulse_sample(1, 16'h0FAB, m);
    for (int k = 0; k < 300; k++) begin
      rx_valid[1] = 1'b1;
      rx_data[1]  = 8'($urandom);
      tick();
      if (k == 9) chk("ovr_after10", ovr[1], 8'd10);
    end
    rx_valid[1] = 1'b0;
    chk("ovr_saturated", ovr[1], 8'd255);
    wait_idle(1, 1000, c);
    set_exp(3, 8'h79, 8'hAB, 8'h0F);
    check_frame(1, base, "w12");

    // Reset in the middle of a frame.
    base = cap0.size();
    send_rx(0, 8'h7A, n);
    tick();
    pulse_sample(0, 16'h1234, m);
    cnt = 0;
    while (cap0.size() < base + 2 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("mid_second_start_seen", 32'(cnt < 100), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", tx_start[0], 1'b0);
    chk("mid_rst_tx_data", tx_data[0], 8'h00);
    chk("mid_rst_ch_sel", ch_sel[0], 2'd0);
    chk("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_ovr1", ovr[1], 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = cap0.size();
    repeat (40) tick();
    chk("mid_no_resend", cap0.size(), cnt);
    base = cap0.size();
    send_rx(0, 8'h78, n);
    tick();
    pulse_sample(0, 16'h00FF, m);
    wait_idle(0, 200, c);
    set_exp(3, 8'h78, 8'hFF, 8'h00);
    check_frame(0, base, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
